branch_redirect_ctrl: RTL and testbench

//  Sequences control flow around the branch unit for the pipelined core variant.
//  - Predicts conditional branches at fetch with a direct-mapped table of 2-bit saturating counters (BHT).
//  - Accepts resolved outcomes (BrOp + NextPCSrc) from the branch unit and trains the BHT.
//  - On a mispredict, issues a PC redirect (valid/ack handshake), then holds flush for a fixed window.
//  - Keeps saturating branch and mispredict counters.

---
 rtl/branch_redirect_ctrl_if.sv | 36 +++
 rtl/branch_redirect_ctrl.sv | 133 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// Fetch lookup, branch resolution and PC redirect signals shared by the core front end and the
// redirect controller; slave is the controller side, master is the core/fetch side.
interface branch_redirect_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      fetch_pc;
   logic             pred_taken;
   logic             resolve_valid;
   logic             resolve_ready;
   logic [31:0]      resolve_pc;
   logic [4:0]       resolve_brop;
   logic             resolve_taken;
   logic             resolve_pred;
   logic [31:0]      resolve_target;
   logic [31:0]      resolve_fallthru;
   logic             redirect_valid;
   logic             redirect_ack;
   logic [31:0]      redirect_pc;
   logic             flush;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   modport slave (
      input  fetch_pc, resolve_valid, resolve_pc, resolve_brop, resolve_taken,
             resolve_pred, resolve_target, resolve_fallthru, redirect_ack,
      output pred_taken, resolve_ready, redirect_valid, redirect_pc, flush,
             branch_cnt, mispred_cnt
   );

   modport master (
      output fetch_pc, resolve_valid, resolve_pc, resolve_brop, resolve_taken,
             resolve_pred, resolve_target, resolve_fallthru, redirect_ack,
      input  pred_taken, resolve_ready, redirect_valid, redirect_pc, flush,
             branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// BHT branch predictor with mispredict redirect/flush sequencing; prediction is combinational, redirect and flush appear one cycle after the accept.
// Resolutions are back-pressured (resolve_ready=0) from the mispredict accept until the flush window ends; redirect is held until acked.
module branch_redirect_ctrl #(
   parameter int BHT_ENTRIES  = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   branch_redirect_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REDIRECT,
      S_FLUSH
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [FC_W-1:0]   r_flush_cnt;
   logic [FC_W-1:0]   w_flush_cnt_nxt;
   logic              r_ready;
   logic              r_redirect_valid;
   logic [31:0]       r_redirect_pc;
   logic              r_flush;
   logic [CNT_W-1:0]  r_branch_cnt;
   logic [CNT_W-1:0]  r_mispred_cnt;
   logic [1:0]        r_bht [BHT_ENTRIES];

   logic [IDX_W-1:0]  w_fetch_idx;
   logic [IDX_W-1:0]  w_resolve_idx;
   logic              w_is_jump;
   logic              w_is_cond;
   logic              w_accept;
   logic              w_counted;
   logic              w_train;
   logic              w_mispred;
   logic              w_unused_bits;

   assign w_fetch_idx   = bus.fetch_pc[IDX_W+1:2];
   assign w_resolve_idx = bus.resolve_pc[IDX_W+1:2];
   assign w_unused_bits = ^{bus.fetch_pc[31:IDX_W+2], bus.fetch_pc[1:0],
                            bus.resolve_pc[31:IDX_W+2], bus.resolve_pc[1:0]};

   assign w_is_jump = (bus.resolve_brop == 5'b11111);
   assign w_is_cond = (bus.resolve_brop == 5'b01000) || (bus.resolve_brop == 5'b01001) ||
                      (bus.resolve_brop == 5'b01100) || (bus.resolve_brop == 5'b01101) ||
                      (bus.resolve_brop == 5'b01110) || (bus.resolve_brop == 5'b01111);

   assign w_accept  = bus.resolve_valid & r_ready;
   assign w_counted = w_accept & (w_is_jump | w_is_cond);
   assign w_train   = w_accept & w_is_cond;
   assign w_mispred = w_counted & (bus.resolve_taken != bus.resolve_pred);

   // Reads the registered table, so a same-cycle update is only visible next cycle.
   assign bus.pred_taken     = r_bht[w_fetch_idx][1];
   assign bus.resolve_ready  = r_ready;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.flush          = r_flush;
   assign bus.branch_cnt     = r_branch_cnt;
   assign bus.mispred_cnt    = r_mispred_cnt;

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_mispred) w_state_nxt = S_REDIRECT;
         end
         S_REDIRECT: begin
            if (bus.redirect_ack) begin
               w_state_nxt     = S_FLUSH;
               w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == '0) w_state_nxt = S_IDLE;
            else                   w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_flush_cnt      <= '0;
         r_ready          <= 1'b1;
         r_redirect_valid <= 1'b0;
         r_flush          <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_flush_cnt      <= w_flush_cnt_nxt;
         r_ready          <= (w_state_nxt == S_IDLE);
         r_redirect_valid <= (w_state_nxt == S_REDIRECT);
         r_flush          <= (w_state_nxt != S_IDLE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_redirect_pc <= '0;
      end else if (w_mispred) begin
         r_redirect_pc <= bus.resolve_taken ? bus.resolve_target : bus.resolve_fallthru;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (w_counted && (r_branch_cnt != '1))  r_branch_cnt  <= r_branch_cnt + CNT_W'(1);
         if (w_mispred && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
      end else if (w_train) begin
         if (bus.resolve_taken && (r_bht[w_resolve_idx] != 2'b11))
            r_bht[w_resolve_idx] <= r_bht[w_resolve_idx] + 2'd1;
         else if (!bus.resolve_taken && (r_bht[w_resolve_idx] != 2'b00))
            r_bht[w_resolve_idx] <= r_bht[w_resolve_idx] - 2'd1;
      end
   end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: BHT training, redirect/flush sequencing,
// BrOp classes, mid-sequence reset and counter saturation.
module tb_branch_redirect_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl_if #(.CNT_W(16)) bus ();

   branch_redirect_ctrl #(
      .BHT_ENTRIES (16),
      .FLUSH_CYCLES(2),
      .CNT_W       (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] brop, input logic tk,
                        input logic pr, input logic [31:0] tgt);
      bus.resolve_valid    = 1'b1;
      bus.resolve_pc       = pc;
      bus.resolve_brop     = brop;
      bus.resolve_taken    = tk;
      bus.resolve_pred     = pr;
      bus.resolve_target   = tgt;
      bus.resolve_fallthru = pc + 32'd4;
   endtask

   task automatic idle_in();
      bus.resolve_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.fetch_pc = 32'h40;
      bus.redirect_ack = 1'b0;
      bus.resolve_valid = 1'b0;
      bus.resolve_pc = '0;
      bus.resolve_brop = '0;
      bus.resolve_taken = 1'b0;
      bus.resolve_pred = 1'b0;
      bus.resolve_target = '0;
      bus.resolve_fallthru = '0;
      step();
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred: got %b want 0", bus.pred_taken); end
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL reset_vfr: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_bad++; $display("FAIL reset_rpc: got %h want 0", bus.redirect_pc); end
      n_cmp++; if ({bus.branch_cnt, bus.mispred_cnt} !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", {bus.branch_cnt, bus.mispred_cnt}); end
   endtask

   task automatic test_train_back_to_back();
      bus.fetch_pc = 32'h40;
      drive(32'h40, 5'b01000, 1'b1, 1'b1, 32'h80);
      #1;
      n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL same_idx_old_pred: got %b want 0", bus.pred_taken); end
      step();
      n_cmp++; if (bus.pred_taken !== 1'b1) begin n_bad++; $display("FAIL train_first: got %b want 1", bus.pred_taken); end
      step();
      step();
      n_cmp++; if (bus.branch_cnt !== 16'd3) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 3", bus.branch_cnt); end
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL train_no_redirect: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      // Saturated at 11: one not-taken keeps predicting taken, the second flips it.
      drive(32'h40, 5'b01001, 1'b0, 1'b0, 32'h80);
      step();
      n_cmp++; if (bus.pred_taken !== 1'b1) begin n_bad++; $display("FAIL sat_hi_dec1: got %b want 1", bus.pred_taken); end
      step();
      n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL sat_hi_dec2: got %b want 0", bus.pred_taken); end
      idle_in();
      n_cmp++; if ({bus.branch_cnt, bus.mispred_cnt} !== {16'd5, 16'd0}) begin n_bad++; $display("FAIL train_cnts: got %h want 00050000", {bus.branch_cnt, bus.mispred_cnt}); end
      bus.fetch_pc = 32'h44;
      #1;
      n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL other_idx: got %b want 0", bus.pred_taken); end
   endtask

   task automatic test_mispredict();
      bus.fetch_pc = 32'h48;
      drive(32'h48, 5'b01100, 1'b1, 1'b0, 32'h100);
      step();
      drive(32'h4C, 5'b11111, 1'b1, 1'b0, 32'h300);
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b110) begin n_bad++; $display("FAIL mp_vfr: got %b want 110", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      n_cmp++; if (bus.redirect_pc !== 32'h100) begin n_bad++; $display("FAIL mp_rpc: got %h want 100", bus.redirect_pc); end
      n_cmp++; if ({bus.branch_cnt, bus.mispred_cnt} !== {16'd6, 16'd1}) begin n_bad++; $display("FAIL mp_cnts: got %h want 00060001", {bus.branch_cnt, bus.mispred_cnt}); end
      n_cmp++; if (bus.pred_taken !== 1'b1) begin n_bad++; $display("FAIL mp_trained: got %b want 1", bus.pred_taken); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready, bus.redirect_pc} !== {3'b110, 32'h100}) begin n_bad++; $display("FAIL hold_%0d: got %b/%h want 110/100", i, {bus.redirect_valid, bus.flush, bus.resolve_ready}, bus.redirect_pc); end
      end
      idle_in();
      n_cmp++; if (bus.branch_cnt !== 16'd6) begin n_bad++; $display("FAIL ignored_resolve: got %0d want 6", bus.branch_cnt); end
      bus.redirect_ack = 1'b1;
      step();
      bus.redirect_ack = 1'b0;
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b010) begin n_bad++; $display("FAIL flush1: got %b want 010", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      step();
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b010) begin n_bad++; $display("FAIL flush2: got %b want 010", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      step();
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL flush_end: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      bus.redirect_ack = 1'b1;
      step();
      bus.redirect_ack = 1'b0;
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL ack_in_idle: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      drive(32'h4C, 5'b01101, 1'b0, 1'b1, 32'h300);
      step();
      idle_in();
      n_cmp++; if ({bus.redirect_valid, bus.redirect_pc, bus.mispred_cnt} !== {1'b1, 32'h50, 16'd2}) begin n_bad++; $display("FAIL fallthru: got %b/%h/%0d want 1/50/2", bus.redirect_valid, bus.redirect_pc, bus.mispred_cnt); end
      bus.redirect_ack = 1'b1;
      step();
      bus.redirect_ack = 1'b0;
      step();
      step();
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL fallthru_end: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
   endtask

   task automatic test_jump_noop();
      bus.fetch_pc = 32'h48;
      drive(32'h48, 5'b11111, 1'b1, 1'b1, 32'h0);
      step();
      n_cmp++; if (bus.branch_cnt !== 16'd8) begin n_bad++; $display("FAIL jump_cnt: got %0d want 8", bus.branch_cnt); end
      drive(32'h48, 5'b11111, 1'b0, 1'b0, 32'h0);
      step();
      n_cmp++; if ({bus.pred_taken, bus.branch_cnt} !== {1'b1, 16'd9}) begin n_bad++; $display("FAIL jump_no_train: got %b/%0d want 1/9", bus.pred_taken, bus.branch_cnt); end
      drive(32'h48, 5'b00000, 1'b0, 1'b1, 32'h500);
      step();
      drive(32'h48, 5'b10101, 1'b0, 1'b1, 32'h500);
      step();
      drive(32'h48, 5'b01010, 1'b0, 1'b1, 32'h500);
      step();
      idle_in();
      n_cmp++; if ({bus.pred_taken, bus.branch_cnt, bus.mispred_cnt} !== {1'b1, 16'd9, 16'd2}) begin n_bad++; $display("FAIL noop: got %b/%0d/%0d want 1/9/2", bus.pred_taken, bus.branch_cnt, bus.mispred_cnt); end
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL noop_vfr: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
   endtask

   task automatic test_reset_mid();
      bus.fetch_pc = 32'h40;
      drive(32'h40, 5'b01000, 1'b1, 1'b0, 32'h600);
      step();
      idle_in();
      bus.redirect_ack = 1'b1;
      step();
      bus.redirect_ack = 1'b0;
      n_cmp++; if ({bus.pred_taken, bus.flush, bus.redirect_valid} !== 3'b110) begin n_bad++; $display("FAIL pre_rst_flush: got %b want 110", {bus.pred_taken, bus.flush, bus.redirect_valid}); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready, bus.pred_taken} !== 4'b0010) begin n_bad++; $display("FAIL rst_in_flush: got %b want 0010", {bus.redirect_valid, bus.flush, bus.resolve_ready, bus.pred_taken}); end
      n_cmp++; if ({bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt} !== 64'h0) begin n_bad++; $display("FAIL rst_in_flush_regs: got %h want 0", {bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt}); end
      step();
      rst = 1'b0;
      drive(32'h40, 5'b01111, 1'b0, 1'b1, 32'h700);
      step();
      idle_in();
      n_cmp++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h44}) begin n_bad++; $display("FAIL pre_rst_redir: got %b/%h want 1/44", bus.redirect_valid, bus.redirect_pc); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({bus.redirect_valid, bus.flush, bus.resolve_ready} !== 3'b001) begin n_bad++; $display("FAIL rst_in_redir: got %b want 001", {bus.redirect_valid, bus.flush, bus.resolve_ready}); end
      n_cmp++; if ({bus.redirect_pc, bus.mispred_cnt} !== 48'h0) begin n_bad++; $display("FAIL rst_in_redir_regs: got %h want 0", {bus.redirect_pc, bus.mispred_cnt}); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_saturation();
      drive(32'h0, 5'b11111, 1'b0, 1'b0, 32'h0);
      repeat (65534) step();
      n_cmp++; if (bus.branch_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre: got %h want fffe", bus.branch_cnt); end
      step();
      n_cmp++; if (bus.branch_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %h want ffff", bus.branch_cnt); end
      step();
      idle_in();
      n_cmp++; if ({bus.branch_cnt, bus.mispred_cnt} !== {16'hFFFF, 16'h0}) begin n_bad++; $display("FAIL sat_hold: got %h want ffff0000", {bus.branch_cnt, bus.mispred_cnt}); end
   endtask

   initial begin
      test_reset();
      test_train_back_to_back();
      test_mispredict();
      test_jump_noop();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
